store_drain_unit: RTL and testbench
===================================

Name: store_drain_unit

Overview:
- Sits directly downstream of the store buffer and receives each evicted entry (data, address, byte flag) through a valid/ready handshake.
- Queues entries in a small FIFO and writes them into the data cache in order.
- Generates byte enables for byte stores.
- On a cache write miss, requests a line refill from memory and retries the write.

Parameters:
DATA_W, 32, data/address width (equals `STOREBUFFER_LINE_SIZE)
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 3, width of occupancy count (clog2(DEPTH)+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
sb_valid  in  1  store buffer presents an entry
sb_ready  out  1  entry accepted this cycle when sb_valid && sb_ready
sb_addr  in  DATA_W  store byte address
sb_data  in  DATA_W  store data (byte stores use bits [7:0])
sb_byte  in  1  1 = byte store, 0 = word store
dc_req  out  1  cache write request, held until dc_ack
dc_addr  out  DATA_W  word-aligned address ([1:0]=0)
dc_wdata  out  DATA_W  write data
dc_be  out  4  byte enables
dc_ack  in  1  one-cycle cache response
dc_miss  in  1  qualifies dc_ack: 1 = miss (nothing written), 0 = write done
mem_req  out  1  refill request, held until mem_done
mem_addr  out  DATA_W  line address of the refill
mem_done  in  1  one-cycle refill completion
empty  out  1  FIFO empty and FSM in IDLE
count  out  CNT_W  FIFO occupancy

Behaviour:
- Reset state (synchronous): FIFO pointers and count = 0, FSM = IDLE.
- Reset output values: sb_ready=1, dc_req=0, mem_req=0, dc_be=0, dc_addr=0, dc_wdata=0, mem_addr=0, empty=1.
- Reset mid-operation: all queued entries are dropped. dc_ack and mem_done arriving after reset are ignored.
- Push:
  - sb_ready = (count != DEPTH).
  - Entry is written at the tail on valid && ready; count increments.
  - No same-cycle bypass: when full, a pop does not make room until the next cycle.
- Entry formatting, fixed at push:
  - Word store: be=4'b1111, data unchanged.
  - Byte store: be = 1 << addr[1:0]; data = {4{sb_data[7:0]}}.
  - Address stored as {addr[DATA_W-1:2],2'b00}.
- FSM states: IDLE, ISSUE, REFILL.
  - IDLE: if FIFO not empty, go to ISSUE next cycle.
  - ISSUE:
    - dc_req=1, and dc_addr/dc_wdata/dc_be show the head entry, all stable until dc_ack.
    - dc_ack && !dc_miss: pop the head (count decrements). Go to ISSUE if more entries remain after the pop (including any pushed this cycle), otherwise IDLE. dc_req drops for at least one cycle between entries.
    - dc_ack && dc_miss: go to REFILL; the head is not popped.
  - REFILL:
    - mem_req=1, mem_addr = head address with the low 4 bits cleared (16-byte line).
    - On mem_done, return to ISSUE and re-issue the same head entry.
    - Retries are unbounded.
- Ordering: strictly FIFO. Stores are never reordered or dropped.
- Simultaneous push and pop: count stays the same and both pointers advance.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- dc_ack outside ISSUE and mem_done outside REFILL are ignored.
- empty = (count==0) && state==IDLE.

Optional Feature:
STORE_DRAIN_COALESCE_EN
- Defined:
  - Coalesce condition: a push whose word address matches the tail-most valid entry, where that entry is not the head currently in ISSUE/REFILL.
  - On coalesce the push merges into that entry instead of allocating: new bytes overwrite according to be, and be becomes the OR of old and new.
  - count does not change. sb_ready stays 1 while a merge is possible, even when full.
- Undefined: every accepted push allocates a new entry.

Decomposition:
- Shared package/constants file: FSM state encodings (IDLE/ISSUE/REFILL), LINE_OFF_BITS=4, the byte-enable width of 4, and a `define for the entry layout {addr, data, be}.
- Natural sub-module: drain_fifo, a parameterised DEPTH x entry FIFO with push/pop/count/full/empty and a tail-entry merge port used only under STORE_DRAIN_COALESCE_EN.
- FSM and formatting stay in the top level.

Test Plan:
- Word store push addr=0x104, data=0xDEADBEEF; cache acks hit 2 cycles later -> dc_addr=0x104, dc_be=4'b1111, dc_wdata=0xDEADBEEF; count returns to 0; empty=1.
- Byte store addr=0x203, data=0xA5 -> dc_addr=0x200, dc_be=4'b1000, dc_wdata=0xA5A5A5A5.
- Miss path: push 0x310; first dc_ack has dc_miss=1 -> mem_req=1 with mem_addr=0x310; after mem_done, dc_req is re-asserted with 0x310; second ack is a hit -> pop.
- Fill and full: push 5 entries back-to-back with dc_ack held 0 -> sb_ready=0 after the 4th; count=4; entries drain in push order 1..4, then the 5th is accepted.
- Reset asserted during REFILL with 3 queued entries -> next cycle mem_req=0, dc_req=0, count=0, empty=1; a mem_done pulse one cycle later is ignored (no dc_req).
- With STORE_DRAIN_COALESCE_EN: while the head stalls in REFILL, push byte 0x401=0x11 then 0x402=0x22 -> one entry, be=4'b0110, count=2 (head + merged).

Source files
------------

// File: rtl/store_drain_unit_pkg.sv
// rtl/store_drain_unit_pkg.sv - Shared FSM encodings, constants and entry layout for the store drain unit
`ifndef STORE_DRAIN_UNIT_PKG_SV
`define STORE_DRAIN_UNIT_PKG_SV

// Queue entry layout, MSB first: word address, write data, byte enables.
`define SDU_ENTRY(addr, data, be) {addr, data, be}

package store_drain_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    localparam int LINE_OFF_BITS = 4;
    localparam int BE_W          = 4;

endpackage

`endif

// File: rtl/store_drain_unit_drain_fifo.sv
// rtl/store_drain_unit_drain_fifo.sv - DEPTH-entry in-order store queue with optional tail-merge port (STORE_DRAIN_COALESCE_EN)
module store_drain_unit_drain_fifo
    import store_drain_unit_pkg::*;
#(
    parameter int ENTRY_W = 68,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_entry_i,
    input  logic               pop_i,
`ifdef STORE_DRAIN_COALESCE_EN
    input  logic               merge_i,
    input  logic [ENTRY_W-1:0] merge_entry_i,
    output logic [ENTRY_W-1:0] tail_o,
`endif
    output logic [ENTRY_W-1:0] head_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

`ifdef STORE_DRAIN_COALESCE_EN
    assign tail_o = mem_q[wr_ptr_q - PTR_W'(1)];
`endif

    // Pointers are exactly PTR_W bits wide, so DEPTH being a power of two makes them wrap for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
`ifdef STORE_DRAIN_COALESCE_EN
        else if (merge_i) begin
            mem_q[wr_ptr_q - PTR_W'(1)] <= merge_entry_i;
        end
`endif
    end

endmodule

// File: rtl/store_drain_unit.sv
// rtl/store_drain_unit.sv - Drains store-buffer evictions into the data cache in order, refilling on write miss
// Optional write coalescing into the tail entry is enabled by defining STORE_DRAIN_COALESCE_EN.
module store_drain_unit
    import store_drain_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sb_valid,
    output logic              sb_ready,
    input  logic [DATA_W-1:0] sb_addr,
    input  logic [DATA_W-1:0] sb_data,
    input  logic              sb_byte,
    output logic              dc_req,
    output logic [DATA_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    output logic [BE_W-1:0]   dc_be,
    input  logic              dc_ack,
    input  logic              dc_miss,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_done,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int ENTRY_W = 2 * DATA_W + BE_W;
    localparam int LANE_W  = DATA_W / BE_W;

    state_e              state_q, state_d;
    logic                gap_q, gap_d;
    logic [ENTRY_W-1:0]  head, push_entry;
    logic [DATA_W-1:0]   head_addr, head_data;
    logic [BE_W-1:0]     head_be;
    logic [DATA_W-1:0]   fmt_addr, fmt_data;
    logic [BE_W-1:0]     fmt_be;
    logic                fifo_full, fifo_empty;
    logic                push, pop, hit_ack, miss_ack, more_after_pop;

    assign `SDU_ENTRY(head_addr, head_data, head_be) = head;
    assign push_entry = `SDU_ENTRY(fmt_addr, fmt_data, fmt_be);

    always_comb begin
        fmt_addr = {sb_addr[DATA_W-1:2], 2'b00};
        fmt_be   = 4'b1111;
        fmt_data = sb_data;
        if (sb_byte) begin
            fmt_be   = BE_W'(1) << sb_addr[1:0];
            fmt_data = {BE_W{sb_data[LANE_W-1:0]}};
        end
    end

`ifdef STORE_DRAIN_COALESCE_EN
    logic [ENTRY_W-1:0] tail, merge_entry;
    logic [DATA_W-1:0]  tail_addr, tail_data, merge_data;
    logic [BE_W-1:0]    tail_be;
    logic               head_busy, merge_ok, merge;

    assign `SDU_ENTRY(tail_addr, tail_data, tail_be) = tail;
    // A lone entry that the FSM is already presenting to the cache must not change under it.
    assign head_busy   = (count == CNT_W'(1)) && (state_q != ST_IDLE);
    assign merge_ok    = !fifo_empty && (tail_addr == fmt_addr) && !head_busy;
    assign sb_ready    = !fifo_full || merge_ok;
    assign merge       = sb_valid && merge_ok;
    assign push        = sb_valid && !merge_ok && !fifo_full;
    assign merge_entry = `SDU_ENTRY(tail_addr, merge_data, tail_be | fmt_be);

    always_comb begin
        merge_data = tail_data;
        for (int i = 0; i < BE_W; i++) begin
            if (fmt_be[i]) begin
                merge_data[i*LANE_W +: LANE_W] = fmt_data[i*LANE_W +: LANE_W];
            end
        end
    end
`else
    assign sb_ready = !fifo_full;
    assign push     = sb_valid && sb_ready;
`endif

    store_drain_unit_drain_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (push),
        .push_entry_i  (push_entry),
        .pop_i         (pop),
`ifdef STORE_DRAIN_COALESCE_EN
        .merge_i       (merge),
        .merge_entry_i (merge_entry),
        .tail_o        (tail),
`endif
        .head_o        (head),
        .count_o       (count),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty)
    );

    assign hit_ack        = dc_req && dc_ack && !dc_miss;
    assign miss_ack       = dc_req && dc_ack && dc_miss;
    assign pop            = hit_ack;
    assign more_after_pop = (count > CNT_W'(1)) || push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // gap_q holds dc_req low for one cycle when the next entry follows directly in ISSUE.
    always_comb begin
        state_d = state_q;
        gap_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (hit_ack) begin
                    state_d = more_after_pop ? ST_ISSUE : ST_IDLE;
                    gap_d   = more_after_pop;
                end else if (miss_ack) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_done) state_d = ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dc_req   = (state_q == ST_ISSUE) && !gap_q;
        mem_req  = (state_q == ST_REFILL);
        dc_addr  = dc_req ? head_addr : '0;
        dc_wdata = dc_req ? head_data : '0;
        dc_be    = dc_req ? head_be : '0;
        mem_addr = mem_req ? {head_addr[DATA_W-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}} : '0;
        empty    = fifo_empty && (state_q == ST_IDLE);
    end

endmodule

// File: tb/tb_store_drain_unit.sv
// tb/tb_store_drain_unit.sv - Scoreboard bench for store_drain_unit (covers STORE_DRAIN_COALESCE_EN when defined)
module tb_store_drain_unit;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;
    localparam int ACK_DLY = 2;
    localparam int MEM_DLY = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              sb_valid, sb_ready, sb_byte;
    logic [DATA_W-1:0] sb_addr, sb_data;
    logic              dc_req, dc_ack, dc_miss;
    logic [DATA_W-1:0] dc_addr, dc_wdata;
    logic [3:0]        dc_be;
    logic              mem_req, mem_done;
    logic [DATA_W-1:0] mem_addr;
    logic              empty;
    logic [CNT_W-1:0]  count;

    store_drain_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sb_valid (sb_valid),
        .sb_ready (sb_ready),
        .sb_addr  (sb_addr),
        .sb_data  (sb_data),
        .sb_byte  (sb_byte),
        .dc_req   (dc_req),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_be    (dc_be),
        .dc_ack   (dc_ack),
        .dc_miss  (dc_miss),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_done (mem_done),
        .empty    (empty),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ack_en = 0;
    int   mem_en = 0;
    int   miss_budget = 0;
    int   misses_seen = 0;
    int   refills_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin : cache_resp
        int wait_cnt;
        wait_cnt = 0;
        dc_ack = 1'b0;
        dc_miss = 1'b0;
        forever begin
            @(posedge clk); #1;
            dc_ack = 1'b0;
            dc_miss = 1'b0;
            if (ack_en != 0 && dc_req && !rst) begin
                wait_cnt++;
                if (wait_cnt >= ACK_DLY) begin
                    dc_ack = 1'b1;
                    wait_cnt = 0;
                    if (miss_budget > 0) begin
                        dc_miss = 1'b1;
                        miss_budget--;
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : mem_resp
        int wait_cnt;
        wait_cnt = 0;
        mem_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (mem_en != 0) begin
                mem_done = 1'b0;
                if (mem_req && !rst) begin
                    wait_cnt++;
                    if (wait_cnt >= MEM_DLY) begin
                        mem_done = 1'b1;
                        wait_cnt = 0;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (mem_req && exp_q.size() > 0)
                chk("mem_addr", mem_addr, exp_q[0].addr & 32'hFFFF_FFF0);
            if (mem_req && mem_done)
                refills_seen++;
            if (dc_req && dc_ack) begin
                if (dc_miss) begin
                    misses_seen++;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr 0x%08h with no store queued", dc_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("dc_addr", dc_addr, e.addr);
                    chk("dc_wdata", dc_wdata, e.data);
                    chk("dc_be", {28'd0, dc_be}, {28'd0, e.be});
                end
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic b,
                        input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] ebe);
        exp_t e;
        int   n;
        e.addr = ea;
        e.data = ed;
        e.be   = ebe;
        exp_q.push_back(e);
        sb_valid = 1'b1;
        sb_addr  = a;
        sb_data  = d;
        sb_byte  = b;
        n = 0;
        @(negedge clk);
        while (!sb_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sb_ready) chk("push_accept_timeout", {31'd0, sb_ready}, 32'd1);
        @(posedge clk); #1;
        sb_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(empty && exp_q.size() == 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_empty"}, {31'd0, empty}, 32'd1);
        chk({name, "_count"}, {29'd0, count}, 32'd0);
        chk({name, "_pending"}, exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_mem_req(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        sb_valid = 1'b0;
        sb_addr = '0;
        sb_data = '0;
        sb_byte = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_sb_ready", {31'd0, sb_ready}, 32'd1);
        chk("rst_dc_req", {31'd0, dc_req}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_dc_be", {28'd0, dc_be}, 32'd0);
        chk("rst_dc_addr", dc_addr, 32'd0);
        chk("rst_dc_wdata", dc_wdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        @(posedge clk); #1;

        // Single word store, then a mix of byte/word stores back-to-back.
        ack_en = 1;
        push(32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111);
        drain("word");
        push(32'h0000_0203, 32'h0000_00A5, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000);
        push(32'h0000_1000, 32'h0000_003C, 1'b1, 32'h0000_1000, 32'h3C3C_3C3C, 4'b0001);
        push(32'h0000_002A, 32'hFFFF_FF7E, 1'b1, 32'h0000_0028, 32'h7E7E_7E7E, 4'b0100);
        push(32'h7FFF_FFFE, 32'hCAFE_F00D, 1'b0, 32'h7FFF_FFFC, 32'hCAFE_F00D, 4'b1111);
        drain("mixed");

        // Miss, refill, retry of the same head.
        misses_seen = 0;
        refills_seen = 0;
        miss_budget = 1;
        mem_en = 1;
        push(32'h0000_0310, 32'h1234_5678, 1'b0, 32'h0000_0310, 32'h1234_5678, 4'b1111);
        drain("miss");
        chk("miss_count", misses_seen, 32'd1);
        chk("refill_count", refills_seen, 32'd1);

        // Fill to DEPTH with the cache stalled; the fifth store waits for room.
        ack_en = 0;
        push(32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_0010, 32'h0000_0001, 4'b1111);
        push(32'h0000_0020, 32'h0000_0002, 1'b0, 32'h0000_0020, 32'h0000_0002, 4'b1111);
        push(32'h0000_0030, 32'h0000_0003, 1'b0, 32'h0000_0030, 32'h0000_0003, 4'b1111);
        push(32'h0000_0040, 32'h0000_0004, 1'b0, 32'h0000_0040, 32'h0000_0004, 4'b1111);
        sb_valid = 1'b1;
        sb_addr = 32'h0000_0050;
        sb_data = 32'h0000_0005;
        sb_byte = 1'b0;
        repeat (3) @(negedge clk);
        chk("full_sb_ready", {31'd0, sb_ready}, 32'd0);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_head_addr", dc_addr, 32'h0000_0010);
        ack_en = 1;
        push(32'h0000_0050, 32'h0000_0005, 1'b0, 32'h0000_0050, 32'h0000_0005, 4'b1111);
        drain("fill");

        // Same-word byte stores while the head is stuck in refill.
        ack_en = 1;
        mem_en = 0;
        miss_budget = 1;
        push(32'h0000_0500, 32'h5555_5555, 1'b0, 32'h0000_0500, 32'h5555_5555, 4'b1111);
        wait_mem_req("coal_refill");
        push(32'h0000_0401, 32'h0000_0011, 1'b1, 32'h0000_0400, 32'h1111_1111, 4'b0010);
`ifdef STORE_DRAIN_COALESCE_EN
        void'(exp_q.pop_back());
        push(32'h0000_0402, 32'h0000_0022, 1'b1, 32'h0000_0400, 32'h1122_1111, 4'b0110);
        @(negedge clk);
        chk("coal_count", {29'd0, count}, 32'd2);
`else
        push(32'h0000_0402, 32'h0000_0022, 1'b1, 32'h0000_0400, 32'h2222_2222, 4'b0100);
        @(negedge clk);
        chk("nocoal_count", {29'd0, count}, 32'd3);
`endif
        @(posedge clk); #1;
        mem_en = 1;
        drain("coal");

        // Reset while in refill with three entries queued.
        mem_en = 0;
        ack_en = 1;
        miss_budget = 1;
        push(32'h0000_0600, 32'h0000_0A00, 1'b0, 32'h0000_0600, 32'h0000_0A00, 4'b1111);
        push(32'h0000_0610, 32'h0000_0A10, 1'b0, 32'h0000_0610, 32'h0000_0A10, 4'b1111);
        push(32'h0000_0620, 32'h0000_0A20, 1'b0, 32'h0000_0620, 32'h0000_0A20, 4'b1111);
        wait_mem_req("rst_refill");
        @(negedge clk);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        ack_en = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_dc_req", {31'd0, dc_req}, 32'd0);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        @(posedge clk); #1;
        mem_done = 1'b1;
        @(posedge clk); #1;
        mem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_done_dc_req", {31'd0, dc_req}, 32'd0);
            chk("late_done_mem_req", {31'd0, mem_req}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
